// File: rtl/reg_file.sv
// rtl/reg_file.sv - RV32I 32 x XLEN register file with debug read port and write counter
// Optional same-cycle write-to-read forwarding on RD1/RD2: REG_FILE_BYPASS_EN
module reg_file #(
   parameter int unsigned            XLEN     = 32,
   parameter logic [XLEN-1:0]        SP_RESET = 32'h0000_3FFC,
   parameter logic [XLEN-1:0]        GP_RESET = 32'h0000_1800
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4:0]      A1,
   input  logic [4:0]      A2,
   input  logic [4:0]      A3,
   input  logic [XLEN-1:0] WD3,
   input  logic            WE3,
   output logic [XLEN-1:0] RD1,
   output logic [XLEN-1:0] RD2,
   input  logic [4:0]      DbgAddr,
   output logic [XLEN-1:0] DbgData,
   output logic [15:0]     WrCount
);

   logic [XLEN-1:0] regs_q [32];
   logic [XLEN-1:0] regs_d [32];
   logic [15:0]     wr_count_q;
   logic [15:0]     wr_count_d;
   logic            wr_commit;

   // x0 is hardwired: a write to it neither lands nor counts
   assign wr_commit = WE3 && (A3 != 5'd0);

   always_comb begin
      regs_d     = regs_q;
      wr_count_d = wr_count_q;
      if (wr_commit) begin
         regs_d[A3] = WD3;
         wr_count_d = wr_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= (i == 2) ? SP_RESET : (i == 3) ? GP_RESET : '0;
         end
         wr_count_q <= 16'd0;
      end else begin
         regs_q     <= regs_d;
         wr_count_q <= wr_count_d;
      end
   end

   always_comb begin
      RD1     = (A1 == 5'd0) ? '0 : regs_q[A1];
      RD2     = (A2 == 5'd0) ? '0 : regs_q[A2];
      DbgData = (DbgAddr == 5'd0) ? '0 : regs_q[DbgAddr];
`ifdef REG_FILE_BYPASS_EN
      // Forward the in-flight write to the ALU operands; debug port sees the array only
      if (wr_commit && (A1 == A3)) RD1 = WD3;
      if (wr_commit && (A2 == A3)) RD2 = WD3;
`endif
   end

   assign WrCount = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed scoreboard bench for reg_file
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [4:0]  A1 = '0, A2 = '0, A3 = '0, DbgAddr = '0;
   logic [31:0] WD3 = '0;
   logic        WE3 = 1'b0;
   logic [31:0] RD1, RD2, DbgData;
   logic [15:0] WrCount;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   reg_file dut (
      .clk(clk), .rst_n(rst_n),
      .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
      .RD1(RD1), .RD2(RD2),
      .DbgAddr(DbgAddr), .DbgData(DbgData), .WrCount(WrCount)
   );

   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL sb_empty observed=%h expected=<none>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      WE3 = 1'b1; A3 = a; WD3 = d;
      @(posedge clk); #1;
      WE3 = 1'b0;
   endtask

   initial begin
      logic [31:0] pat;
      // 1. reset, then release
      #2 rst_n = 1'b0;
      A1 = 5'd2; A2 = 5'd3; #1;
      push("rst_sp", 32'h0000_3FFC); check(RD1);
      push("rst_gp", 32'h0000_1800); check(RD2);
      A1 = 5'd5; #1;
      push("rst_x5", 32'h0); check(RD1);
      push("rst_cnt", 32'h0); check({16'h0, WrCount});
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      A1 = 5'd2; A2 = 5'd3; #1;
      push("rel_sp", 32'h0000_3FFC); check(RD1);
      push("rel_gp", 32'h0000_1800); check(RD2);
      push("rel_cnt", 32'h0); check({16'h0, WrCount});

      // 2. basic write/read
      write(5'd5, 32'h0000_000C);
      A1 = 5'd5; A2 = 5'd5; #1;
      push("wr_rd1", 32'h0000_000C); check(RD1);
      push("wr_rd2", 32'h0000_000C); check(RD2);
      push("wr_cnt", 32'd1); check({16'h0, WrCount});

      // WE3=0 changes nothing
      WE3 = 1'b0; A3 = 5'd5; WD3 = 32'hCAFE_F00D;
      @(posedge clk); #1;
      push("we0_x5", 32'h0000_000C); check(RD1);
      push("we0_cnt", 32'd1); check({16'h0, WrCount});

      // 3. x0 protection
      write(5'd0, 32'hDEAD_BEEF);
      A1 = 5'd0; DbgAddr = 5'd0; #1;
      push("x0_rd1", 32'h0); check(RD1);
      push("x0_dbg", 32'h0); check(DbgData);
      push("x0_cnt", 32'd1); check({16'h0, WrCount});

      // 4. same-cycle hazard
      write(5'd7, 32'h1111_1111);
      WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h2222_2222;
      A1 = 5'd7; A2 = 5'd7; DbgAddr = 5'd7; #1;
`ifdef REG_FILE_BYPASS_EN
      push("haz_pre_rd1", 32'h2222_2222); check(RD1);
      push("haz_pre_rd2", 32'h2222_2222); check(RD2);
`else
      push("haz_pre_rd1", 32'h1111_1111); check(RD1);
      push("haz_pre_rd2", 32'h1111_1111); check(RD2);
`endif
      push("haz_pre_dbg", 32'h1111_1111); check(DbgData);
      @(posedge clk); #1;
      WE3 = 1'b0; #1;
      push("haz_post_rd1", 32'h2222_2222); check(RD1);
      push("haz_post_rd2", 32'h2222_2222); check(RD2);
      push("haz_post_dbg", 32'h2222_2222); check(DbgData);
      push("haz_cnt", 32'd3); check({16'h0, WrCount});

      // 5. async reset mid-write
      write(5'd9, 32'hA5A5_A5A5);
      A1 = 5'd9; A2 = 5'd2; #1;
      push("x9_written", 32'hA5A5_A5A5); check(RD1);
      WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h5A5A_5A5A;
      @(negedge clk); rst_n = 1'b0; #1;
      push("arst_x9", 32'h0); check(RD1);
      push("arst_sp", 32'h0000_3FFC); check(RD2);
      push("arst_cnt", 32'h0); check({16'h0, WrCount});
      WE3 = 1'b0; #1 rst_n = 1'b1;
      @(posedge clk); #1;
      push("arst_x9_after", 32'h0); check(RD1);
      push("arst_cnt_after", 32'h0); check({16'h0, WrCount});

      // 6. full sweep
      for (int a = 1; a < 32; a++) begin
         pat = {27'h0, 5'(a)} ^ 32'hFFFF_0000;
         write(5'(a), pat);
      end
      for (int a = 1; a < 32; a++) begin
         pat = {27'h0, 5'(a)} ^ 32'hFFFF_0000;
         DbgAddr = 5'(a); A1 = 5'(a); A2 = 5'(32 - a); #1;
         push($sformatf("sweep_dbg_%0d", a), pat); check(DbgData);
         push($sformatf("sweep_rd1_%0d", a), pat); check(RD1);
         push($sformatf("sweep_rd2_%0d", 32 - a), {27'h0, 5'(32 - a)} ^ 32'hFFFF_0000);
         check(RD2);
      end
      push("sweep_cnt", 32'd31); check({16'h0, WrCount});

      // counter wrap: 31 + 65504 = 65535, then one more
      WE3 = 1'b1; A3 = 5'd1; WD3 = 32'h0BAD_0001;
      repeat (65504) @(posedge clk);
      #1 WE3 = 1'b0; #1;
      push("cnt_ffff", 32'h0000_FFFF); check({16'h0, WrCount});
      write(5'd1, 32'h1234_5678);
      push("cnt_wrap", 32'h0); check({16'h0, WrCount});
      A1 = 5'd1; #1;
      push("wrap_x1", 32'h1234_5678); check(RD1);

      if (sb.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
